// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg: shared types and bounds for the N-way pipelined multiplexer.
package mux_pipe_pkg;

    // Arbitration mode, as driven on rr_mode
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Legal parameter bounds
    localparam int NUM_IN_MIN = 2;
    localparam int NUM_IN_MAX = 16;
    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 64;

    // Channel index wide enough for the largest legal channel count
    localparam int CH_IDX_W = $clog2(NUM_IN_MAX);
    typedef logic [CH_IDX_W-1:0] ch_idx_t;

endpackage

// File: rtl/mux_pipe_nway_rr_arbiter.sv
// rr_arbiter: combinational wrap-around priority search. Picks the lowest
// requesting index at or above ptr, wrapping past NUM_IN-1 back to 0.
// ptr must be below NUM_IN; the owner of ptr guarantees this.
module rr_arbiter
    import mux_pipe_pkg::*;
#(
    parameter  int NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              grant_valid,
    output logic [SEL_W-1:0]  grant_idx
);

    // Scan offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_pipe_nway.sv
// mux_pipe_nway: N-way valid/ready multiplexer with a single registered
// output stage. Fixed mode takes channel sel; round-robin mode (built only
// when MUX_PIPE_RR_EN is defined) rotates through valid channels starting
// at ptr. Without MUX_PIPE_RR_EN, rr_mode is ignored and only fixed mode
// exists.
module mux_pipe_nway
    import mux_pipe_pkg::*;
#(
    parameter  int NUM_IN = 8,
    parameter  int WIDTH  = 32,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    rr_mode,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    logic             can_load;
    logic             sel_in_range;
    logic             cand_valid;
    logic [SEL_W-1:0] cand_idx;
    logic             load;
    logic [WIDTH-1:0] cand_data;

    // Output stage may take a new word when empty or draining this cycle
    assign can_load     = !out_valid || out_ready;
    assign sel_in_range = int'(sel) < NUM_IN;

`ifdef MUX_PIPE_RR_EN
    logic             rr_grant_valid;
    logic [SEL_W-1:0] rr_grant_idx;
    logic [SEL_W-1:0] ptr;
    mode_e            mode;

    assign mode = mode_e'(rr_mode);

    rr_arbiter #(
        .NUM_IN(NUM_IN)
    ) u_arb (
        .req        (in_valid),
        .ptr        (ptr),
        .grant_valid(rr_grant_valid),
        .grant_idx  (rr_grant_idx)
    );

    // Candidate comes from the arbiter or from sel, chosen live each cycle
    always_comb begin
        cand_valid = sel_in_range;
        cand_idx   = sel;
        if (mode == MODE_RR) begin
            cand_valid = rr_grant_valid;
            cand_idx   = rr_grant_idx;
        end
    end

    // Rotate priority past the channel that just completed a handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= (cand_idx == SEL_W'(NUM_IN - 1)) ? '0 : cand_idx + 1'b1;
        end
    end
`else
    logic unused_rr_mode;

    assign unused_rr_mode = rr_mode;
    assign cand_valid     = sel_in_range;
    assign cand_idx       = sel;
`endif

    // Ready goes only to the candidate and never looks at its valid bit
    always_comb begin
        in_ready = '0;
        if (cand_valid) begin
            in_ready[cand_idx] = can_load;
        end
    end

    assign load      = cand_valid && in_valid[cand_idx] && can_load;
    assign cand_data = in_data[int'(cand_idx)*WIDTH +: WIDTH];

    // Output register: load on handshake, else drop valid once accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= cand_data;
            out_sel   <= cand_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_pipe_nway.sv
// tb_mux_pipe_nway: directed stimulus for mux_pipe_nway (8x32 main instance
// plus a 5x8 instance for out-of-range select), with a per-cycle
// behavioural model and hand-computed literal expectations.
module tb_mux_pipe_nway;

    localparam int N   = 8;
    localparam int W   = 32;
    localparam int SW  = 3;
    localparam int N5  = 5;
    localparam int W5  = 8;
    localparam int SW5 = 3;

    logic clk = 1'b0;
    logic rst_n;

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic           rr_mode;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_ready;

    logic [N5-1:0]    p_in_valid;
    logic [N5*W5-1:0] p_in_data;
    logic [N5-1:0]    p_in_ready;
    logic [SW5-1:0]   p_sel;
    logic             p_rr_mode;
    logic             p_out_valid;
    logic [W5-1:0]    p_out_data;
    logic [SW5-1:0]   p_out_sel;
    logic             p_out_ready;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mux_pipe_nway #(.NUM_IN(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .sel(sel), .rr_mode(rr_mode),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    mux_pipe_nway #(.NUM_IN(N5), .WIDTH(W5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(p_in_valid), .in_data(p_in_data), .in_ready(p_in_ready),
        .sel(p_sel), .rr_mode(p_rr_mode),
        .out_valid(p_out_valid), .out_data(p_out_data), .out_sel(p_out_sel),
        .out_ready(p_out_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Behavioural model: expected output word and ready pattern
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [SW-1:0] m_sel;
    int           m_ptr;

    always @(negedge clk) begin
        int   cand;
        bit   cand_ok;
        bit   can_ld;
        bit   rr;
        logic [N-1:0] exp_rdy;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = '0;
            m_ptr   = 0;
        end
        rr = 1'b0;
`ifdef MUX_PIPE_RR_EN
        rr = rr_mode;
`endif
        cand_ok = 1'b0;
        cand    = 0;
        if (!rr) begin
            if (int'(sel) < N) begin
                cand_ok = 1'b1;
                cand    = int'(sel);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!cand_ok && in_valid[(m_ptr + k) % N]) begin
                    cand_ok = 1'b1;
                    cand    = (m_ptr + k) % N;
                end
            end
        end
        can_ld  = !m_valid || out_ready;
        exp_rdy = '0;
        if (cand_ok && can_ld) exp_rdy[cand] = 1'b1;

        check("model_out_valid", 64'(out_valid), 64'(m_valid));
        check("model_out_data",  64'(out_data),  64'(m_data));
        check("model_out_sel",   64'(out_sel),   64'(m_sel));
        check("model_in_ready",  64'(in_ready),  64'(exp_rdy));

        if (rst_n) begin
            if (cand_ok && in_valid[cand] && can_ld) begin
                m_valid = 1'b1;
                m_data  = in_data[cand*W +: W];
                m_sel   = SW'(cand);
                m_ptr   = (cand + 1) % N;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        rr_mode   = 1'b0;
        sel       = 3'd5;
        in_valid  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hC0DE_0000 + i;
        in_data[5*W +: W] = 32'hDEAD_BEEF;
        p_rr_mode   = 1'b0;
        p_sel       = '0;
        p_in_valid  = '0;
        p_out_ready = 1'b1;
        for (int i = 0; i < N5; i++) p_in_data[i*W5 +: W5] = 8'h40 + 8'(i);

        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data",  64'(out_data),  64'd0);
        check("reset_out_sel",   64'(out_sel),   64'd0);

        // Fixed select of channel 5
        in_valid = 8'hFF;
        #1;
        check("fixed_ready_pre", 64'(in_ready), 64'h20);
        cyc();
        check("fixed_out_valid", 64'(out_valid), 64'd1);
        check("fixed_out_data",  64'(out_data),  64'hDEADBEEF);
        check("fixed_out_sel",   64'(out_sel),   64'd5);
        check("fixed_in_ready",  64'(in_ready),  64'h20);

        // Backpressure with a select change while the word is held
        out_ready = 1'b0;
        in_data[5*W +: W] = 32'h5555_5555;
        #1;
        check("bp_ready_low", 64'(in_ready), 64'h0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (c == 1) sel = 3'd2;
            #1;
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data",  64'(out_data),  64'hDEADBEEF);
            check("bp_hold_sel",   64'(out_sel),   64'd5);
            check("bp_hold_ready", 64'(in_ready),  64'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'h04);
        cyc();
        check("bp_nobubble_valid", 64'(out_valid), 64'd1);
        check("bp_nobubble_data",  64'(out_data),  64'hC0DE0002);
        check("bp_nobubble_sel",   64'(out_sel),   64'd2);
        cyc();
        check("stream_valid", 64'(out_valid), 64'd1);

        // Selected channel idle: ready still offered, output drains
        sel      = 3'd4;
        in_valid = 8'h00;
        #1;
        check("idle_ready", 64'(in_ready), 64'h10);
        cyc();
        check("idle_drain_valid", 64'(out_valid), 64'd0);
        check("idle_hold_data",   64'(out_data),  64'hC0DE0002);

        // Reset in the middle of a transfer
        sel      = 3'd1;
        in_valid = 8'hFF;
        cyc();
        check("pre_rst_data", 64'(out_data), 64'hC0DE0001);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_data",  64'(out_data),  64'd0);
        check("rst_mid_sel",   64'(out_sel),   64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;

`ifdef MUX_PIPE_RR_EN
        // Round-robin over all channels, then over channels 2 and 6
        rr_mode  = 1'b1;
        in_valid = 8'hFF;
        for (int i = 0; i <= N; i++) begin
            cyc();
            check("rr_all_sel", 64'(out_sel), 64'(i % N));
        end
        in_valid = 8'h44;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("rr_pair_sel", 64'(out_sel), (i % 2 == 0) ? 64'd2 : 64'd6);
        end
`else
        // Without round-robin support rr_mode is ignored
        rr_mode  = 1'b1;
        sel      = 3'd3;
        in_valid = 8'hFF;
        #1;
        check("norr_ready", 64'(in_ready), 64'h08);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("norr_sel",  64'(out_sel),  64'd3);
            check("norr_data", 64'(out_data), 64'hC0DE0003);
        end
`endif

        // Out-of-range select on the 5-channel instance
        p_sel      = 3'd6;
        p_in_valid = 5'h1F;
        #1;
        check("oor_ready", 64'(p_in_ready), 64'h0);
        cyc();
        check("oor_valid_1", 64'(p_out_valid), 64'd0);
        cyc();
        check("oor_valid_2", 64'(p_out_valid), 64'd0);
        p_sel = 3'd4;
        #1;
        check("n5_ready", 64'(p_in_ready), 64'h10);
        cyc();
        check("n5_valid", 64'(p_out_valid), 64'd1);
        check("n5_data",  64'(p_out_data),  64'h44);
        check("n5_sel",   64'(p_out_sel),   64'd4);

        cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
